aftab_dawu: RTL and testbench

- Data Adjustment Write Unit (DAWU) in the AFTAB datapath, between the load/store path and the byte-wide data memory port.
- Takes a store request (address, 32-bit data, size) and serialises it into 1–4 single-byte memory writes.
- Handshakes each byte with the memory-ready signal, then reports completion.
- Optionally flags misaligned stores.

---
 rtl/aftab_dawu.sv | 117 +++++++++++
 tb/tb_aftab_dawu.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aftab_dawu.sv
// aftab_dawu: data adjustment write unit. Serialises a 1-4 byte store into
// single-byte memory writes, handshaking each byte with memReady.
// Ports: clk, rst (async active-low); addrIn/dataIn/nBytes/startDAWU request;
//   memReady byte accept; checkMisalignedDAWU enables alignment check;
//   addrOut/dataOut/writeMem byte port; completeDAWU done pulse;
//   storeMisalignedFlag combinational misalignment indication.
// Option: define AFTAB_DAWU_BIG_ENDIAN_EN to emit bytes MSB-first.
module aftab_dawu #(
    parameter int len = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [len-1:0] addrIn,
    input  logic [len-1:0] dataIn,
    input  logic [1:0]     nBytes,
    input  logic           startDAWU,
    input  logic           memReady,
    input  logic           checkMisalignedDAWU,
    output logic [len-1:0] addrOut,
    output logic [7:0]     dataOut,
    output logic           storeMisalignedFlag,
    output logic           completeDAWU,
    output logic           writeMem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT          state;
    stateT          nextState;
    logic [len-1:0] addrReg;
    logic [len-1:0] dataReg;
    logic [1:0]     countReg;
    logic [1:0]     index;
    logic [1:0]     lane;
    logic           accept;
    logic           lastByte;

    // nBytes=0 is always aligned; halfwords need bit 0 clear,
    // anything wider needs both low bits clear.
    always_comb begin
        storeMisalignedFlag = 1'b0;
        if (checkMisalignedDAWU) begin
            if (nBytes == 2'd1)
                storeMisalignedFlag = addrIn[0];
            else if (nBytes != 2'd0)
                storeMisalignedFlag = (addrIn[1:0] != 2'b00);
        end
    end

    assign accept   = (state == IDLE) && startDAWU && !storeMisalignedFlag;
    assign lastByte = (index == countReg);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (accept) nextState = WRITE;
            WRITE:   if (memReady && lastByte) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request latch and byte index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrReg  <= '0;
            dataReg  <= '0;
            countReg <= 2'd0;
            index    <= 2'd0;
        end else if (accept) begin
            addrReg  <= addrIn;
            dataReg  <= dataIn;
            countReg <= nBytes;
            index    <= 2'd0;
        end else if (state == WRITE && memReady && !lastByte) begin
            index <= index + 2'd1;
        end
    end

`ifdef AFTAB_DAWU_BIG_ENDIAN_EN
    // index never exceeds countReg, so the subtraction cannot wrap.
    assign lane = countReg - index;
`else
    assign lane = index;
`endif

    // Output logic
    always_comb begin
        writeMem     = 1'b0;
        completeDAWU = 1'b0;
        addrOut      = '0;
        dataOut      = 8'h00;
        unique case (state)
            WRITE: begin
                writeMem = 1'b1;
                addrOut  = addrReg + len'(index);
                dataOut  = 8'(dataReg >> {lane, 3'b000});
            end
            DONE:    completeDAWU = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aftab_dawu.sv
// tb_aftab_dawu: self-checking bench for aftab_dawu, using a byte-list
// reference model of each store and randomised memReady timing.
module tb_aftab_dawu;

    logic        clk;
    logic        rst;
    logic [31:0] addrIn;
    logic [31:0] dataIn;
    logic [1:0]  nBytes;
    logic        startDAWU;
    logic        memReady;
    logic        checkMisalignedDAWU;
    logic [31:0] addrOut;
    logic [7:0]  dataOut;
    logic        storeMisalignedFlag;
    logic        completeDAWU;
    logic        writeMem;

    int nCompared = 0;
    int nMismatch = 0;

    aftab_dawu #(.len(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .addrIn              (addrIn),
        .dataIn              (dataIn),
        .nBytes              (nBytes),
        .startDAWU           (startDAWU),
        .memReady            (memReady),
        .checkMisalignedDAWU (checkMisalignedDAWU),
        .addrOut             (addrOut),
        .dataOut             (dataOut),
        .storeMisalignedFlag (storeMisalignedFlag),
        .completeDAWU        (completeDAWU),
        .writeMem            (writeMem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit modelFlag(input logic [31:0] a, input logic [1:0] n,
                                     input logic chk);
        if (!chk || n == 2'd0) return 1'b0;
        if (n == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [7:0] modelByte(input logic [31:0] d,
                                             input logic [1:0] n, input int i);
`ifdef AFTAB_DAWU_BIG_ENDIAN_EN
        return 8'((d >> (8 * (int'(n) - i))) & 32'hFF);
`else
        return 8'((d >> (8 * i)) & 32'hFF);
`endif
    endfunction

    // Issue one store and check every byte written plus the completion pulse.
    // mode: 0 random ready, 1 ready every 4th cycle, 2 ready always.
    task automatic doStore(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] n, input logic chk,
                           input int mode, input string name);
        logic [31:0] expA[$];
        logic [7:0]  expD[$];
        logic [31:0] pa;
        logic [7:0]  pd;
        int          got;
        int          cyc;
        bit          done;
        bit          prevStall;
        for (int i = 0; i <= int'(n); i++) begin
            expA.push_back(32'(a + 32'(i)));
            expD.push_back(modelByte(d, n, i));
        end
        addrIn = a; dataIn = d; nBytes = n;
        checkMisalignedDAWU = chk;
        startDAWU = 1'b1;
        memReady = 1'bx;
        step();
        startDAWU = 1'b0;
        addrIn = $urandom; dataIn = $urandom;
        nBytes = 2'($urandom_range(0, 3));
        got = 0; done = 0; prevStall = 0; cyc = 0;
        pa = '0; pd = '0;
        while (!done && cyc < 300) begin
            if (completeDAWU) begin
                done = 1;
            end else begin
                nCompared++;
                if (writeMem !== 1'b1) begin
                    nMismatch++;
                    $display("FAIL %s writeMem: got %b expected 1 cyc %0d",
                             name, writeMem, cyc);
                end
                if (prevStall) begin
                    nCompared++;
                    if (addrOut !== pa || dataOut !== pd) begin
                        nMismatch++;
                        $display("FAIL %s stall hold: got %h/%h expected %h/%h",
                                 name, addrOut, dataOut, pa, pd);
                    end
                end
                unique case (mode)
                    1:       memReady = (cyc % 4 == 3);
                    2:       memReady = 1'b1;
                    default: memReady = 1'($urandom_range(0, 1));
                endcase
                if (memReady) begin
                    nCompared++;
                    if (got > int'(n)) begin
                        nMismatch++;
                        $display("FAIL %s extra write: got %h@%h expected none",
                                 name, dataOut, addrOut);
                    end else if (addrOut !== expA[got] || dataOut !== expD[got]) begin
                        nMismatch++;
                        $display("FAIL %s byte%0d: got %h@%h expected %h@%h",
                                 name, got, dataOut, addrOut, expD[got], expA[got]);
                    end
                    got++;
                end
                prevStall = !memReady;
                pa = addrOut; pd = dataOut;
                step();
                cyc++;
            end
        end
        nCompared++;
        if (!done || got != int'(n) + 1) begin
            nMismatch++;
            $display("FAIL %s completion: got done=%0d writes=%0d expected 1/%0d",
                     name, done, got, int'(n) + 1);
        end
        nCompared++;
        if (writeMem !== 1'b0) begin
            nMismatch++;
            $display("FAIL %s done writeMem: got %b expected 0", name, writeMem);
        end
        memReady = 1'b0;
        step();
        nCompared++;
        if (completeDAWU !== 1'b0 || writeMem !== 1'b0) begin
            nMismatch++;
            $display("FAIL %s idle after done: got c=%b w=%b expected 0/0",
                     name, completeDAWU, writeMem);
        end
    endtask

    task automatic expectNoWrite(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            step();
            nCompared++;
            if (writeMem !== 1'b0 || completeDAWU !== 1'b0) begin
                nMismatch++;
                $display("FAIL %s no write: got w=%b c=%b expected 0/0",
                         name, writeMem, completeDAWU);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        addrIn = '0; dataIn = '0; nBytes = '0;
        startDAWU = 1'b0; memReady = 1'bx; checkMisalignedDAWU = 1'b0;
        #40;
        nCompared++;
        if ({writeMem, completeDAWU, storeMisalignedFlag, addrOut, dataOut} !== '0) begin
            nMismatch++;
            $display("FAIL reset outputs: got %b %b %b %h %h expected zeros",
                     writeMem, completeDAWU, storeMisalignedFlag, addrOut, dataOut);
        end
        @(negedge clk);
        rst = 1'b1;
        expectNoWrite(3, "reset idle");
    endtask

    task automatic test_word();
        doStore(32'h0300FF55, 32'hAA00FF0F, 2'd3, 1'b0, 1, "word");
    endtask

    task automatic test_byte_half();
        doStore(32'h00000100, 32'h12345678, 2'd0, 1'b0, 2, "byte");
        doStore(32'h00000200, 32'h12345678, 2'd1, 1'b0, 0, "half");
        doStore(32'h00000300, 32'h12345678, 2'd2, 1'b0, 0, "three");
    endtask

    task automatic test_misaligned();
        addrIn = 32'h1002; nBytes = 2'd3; checkMisalignedDAWU = 1'b1;
        dataIn = 32'hDEADBEEF;
        #1;
        nCompared++;
        if (storeMisalignedFlag !== 1'b1) begin
            nMismatch++;
            $display("FAIL misaligned word flag: got %b expected 1",
                     storeMisalignedFlag);
        end
        startDAWU = 1'b1;
        expectNoWrite(5, "misaligned word");
        startDAWU = 1'b0;
        nBytes = 2'd1;
        #1;
        nCompared++;
        if (storeMisalignedFlag !== 1'b0) begin
            nMismatch++;
            $display("FAIL aligned half flag: got %b expected 0",
                     storeMisalignedFlag);
        end
        doStore(32'h1002, 32'hCAFEF00D, 2'd1, 1'b1, 0, "aligned half");
        addrIn = 32'h1003; nBytes = 2'd3; checkMisalignedDAWU = 1'b0;
        #1;
        nCompared++;
        if (storeMisalignedFlag !== 1'b0) begin
            nMismatch++;
            $display("FAIL unchecked flag: got %b expected 0",
                     storeMisalignedFlag);
        end
        doStore(32'h1003, 32'h01020304, 2'd3, 1'b0, 0, "unchecked");
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [1:0]  n;
            logic        c;
            a = $urandom; n = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1));
            addrIn = a; nBytes = n; checkMisalignedDAWU = c;
            #1;
            nCompared++;
            if (storeMisalignedFlag !== modelFlag(a, n, c)) begin
                nMismatch++;
                $display("FAIL flag a=%h n=%0d c=%b: got %b expected %b",
                         a, n, c, storeMisalignedFlag, modelFlag(a, n, c));
            end
        end
        checkMisalignedDAWU = 1'b0;
    endtask

    task automatic test_wrap();
        doStore(32'hFFFFFFFE, 32'h44332211, 2'd3, 1'b0, 0, "wrap");
    endtask

    task automatic test_reset_mid();
        addrIn = 32'h4000; dataIn = 32'h89ABCDEF; nBytes = 2'd3;
        checkMisalignedDAWU = 1'b0;
        startDAWU = 1'b1;
        step();
        startDAWU = 1'b0;
        memReady = 1'b1;
        step();
        step();
        memReady = 1'b0;
        #3 rst = 1'b0;
        #1;
        nCompared++;
        if ({writeMem, completeDAWU, addrOut, dataOut} !== '0) begin
            nMismatch++;
            $display("FAIL reset mid: got %b %b %h %h expected zeros",
                     writeMem, completeDAWU, addrOut, dataOut);
        end
        expectNoWrite(3, "reset held");
        rst = 1'b1;
        expectNoWrite(2, "after reset");
        doStore(32'h5000, 32'h76543210, 2'd3, 1'b0, 2, "post reset");
    endtask

    task automatic test_held_start();
        int cyc;
        logic [7:0] sd;
        logic [31:0] sa;
        addrIn = 32'h6000; dataIn = 32'h0000BEEF; nBytes = 2'd1;
        checkMisalignedDAWU = 1'b0;
        startDAWU = 1'b1;
        memReady = 1'b1;
        step();
        cyc = 0;
        while (!completeDAWU && cyc < 20) begin
            step();
            cyc++;
        end
        nCompared++;
        if (completeDAWU !== 1'b1) begin
            nMismatch++;
            $display("FAIL held start complete: got %b expected 1", completeDAWU);
        end
        memReady = 1'b0;
        step();
        nCompared++;
        if (writeMem !== 1'b0 || completeDAWU !== 1'b0) begin
            nMismatch++;
            $display("FAIL held start idle: got w=%b c=%b expected 0/0",
                     writeMem, completeDAWU);
        end
        step();
        startDAWU = 1'b0;
        nCompared++;
        if (writeMem !== 1'b1 || addrOut !== 32'h6000 ||
            dataOut !== modelByte(32'h0000BEEF, 2'd1, 0)) begin
            nMismatch++;
            $display("FAIL held start restart: got w=%b %h@%h expected 1 %h@6000",
                     writeMem, dataOut, addrOut, modelByte(32'h0000BEEF, 2'd1, 0));
        end
        sa = addrOut; sd = dataOut;
        for (int i = 0; i < 20; i++) begin
            addrIn = $urandom; dataIn = $urandom;
            step();
            nCompared++;
            if (writeMem !== 1'b1 || addrOut !== sa || dataOut !== sd) begin
                nMismatch++;
                $display("FAIL stall stable: got w=%b %h@%h expected 1 %h@%h",
                         writeMem, dataOut, addrOut, sd, sa);
            end
        end
        memReady = 1'b1;
        step();
        nCompared++;
        if (addrOut !== 32'h6001 || dataOut !== modelByte(32'h0000BEEF, 2'd1, 1)) begin
            nMismatch++;
            $display("FAIL stall resume: got %h@%h expected %h@6001",
                     dataOut, addrOut, modelByte(32'h0000BEEF, 2'd1, 1));
        end
        step();
        nCompared++;
        if (completeDAWU !== 1'b1) begin
            nMismatch++;
            $display("FAIL stall complete: got %b expected 1", completeDAWU);
        end
        memReady = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [1:0]  n;
            logic        c;
            a = $urandom; d = $urandom;
            n = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1));
            if (modelFlag(a, n, c)) begin
                addrIn = a; dataIn = d; nBytes = n; checkMisalignedDAWU = c;
                startDAWU = 1'b1;
                expectNoWrite(2, "random misaligned");
                startDAWU = 1'b0;
            end else begin
                doStore(a, d, n, c, 0, "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_held_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatch);
        $finish;
    end

endmodule
